// File: rtl/priority_grant_pkg.sv
// Shared constants for the priority grant decoder: FSM state encoding and
// the width of the encoded request index.
package priority_grant_pkg;

    localparam int IDX_W   = 2;
    localparam int GRANT_W = 1 << IDX_W;

    typedef logic [IDX_W-1:0]   idx_t;
    typedef logic [GRANT_W-1:0] grant_t;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

endpackage

// File: rtl/dec_2to4.sv
// Combinational 2-to-4 one-hot decoder used to build the grant vector.
module dec_2to4
    import priority_grant_pkg::*;
(
    input  logic [IDX_W-1:0]   idx,
    output logic [GRANT_W-1:0] onehot
);

    for (genvar gi = 0; gi < GRANT_W; gi++) begin : g_bit
        assign onehot[gi] = (idx == idx_t'(gi));
    end

endmodule

// File: rtl/priority_grant_decoder.sv
// Grants one of four requesters from an encoded {A,B} index and holds the grant until ack.
// Optional grant revocation after TIMEOUT_CYCLES is enabled by defining GRANT_TIMEOUT_EN.
module priority_grant_decoder
    import priority_grant_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 8
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         A,
    input  logic         B,
    input  logic         V,
    input  logic         ack,
    output logic [3:0]   G,
    output logic         busy,
    output logic         err
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 2..255");
    end

    logic [1:0]         state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [GRANT_W-1:0] g_reg, g_next;
    logic [GRANT_W-1:0] dec_onehot;
    logic               timeout_hit;

`ifdef GRANT_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_reg, cnt_next;
    logic       err_reg;

    // ack in the final cycle takes priority over the revocation
    assign timeout_hit = (state_reg == GRANT) && !ack && (cnt_reg == TIMEOUT_LAST);

    always_comb begin
        cnt_next = cnt_reg;
        if (state_reg != GRANT) begin
            cnt_next = 8'd0;
        end else if (!ack) begin
            cnt_next = cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= 8'd0;
            err_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            err_reg <= timeout_hit;
        end
    end

    assign err = err_reg;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                if (V) begin
                    state_next = GRANT;
                    idx_next   = {A, B};
                end
            end
            GRANT: begin
                if (ack || timeout_hit) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Decode the next index so the registered grant appears one cycle after capture
    dec_2to4 u_dec (
        .idx    (idx_next),
        .onehot (dec_onehot)
    );

    assign g_next = (state_next == GRANT) ? dec_onehot : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            g_reg     <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            g_reg     <= g_next;
        end
    end

    assign G    = g_reg;
    assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_priority_grant_decoder.sv
// Self-checking bench for priority_grant_decoder; timeout scenarios run when GRANT_TIMEOUT_EN is defined.
module tb_priority_grant_decoder;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       A, B, V, ack;
    logic [3:0] G;
    logic       busy, err;

    int total = 0;
    int bad   = 0;

    // Reference model: granted index (-1 = none), release-pending flag, grant age
    int m_idx  = -1;
    bit m_rel  = 1'b0;
    bit m_err  = 1'b0;
    int m_held = 0;

    priority_grant_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .V    (V),
        .ack  (ack),
        .G    (G),
        .busy (busy),
        .err  (err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_idx  = -1;
        m_rel  = 1'b0;
        m_err  = 1'b0;
        m_held = 0;
    endtask

    task automatic model_step();
        if (m_idx >= 0) begin
            m_held++;
            if (ack) begin
                m_idx = -1; m_rel = 1'b1; m_err = 1'b0;
            end
`ifdef GRANT_TIMEOUT_EN
            else if (m_held == TO) begin
                m_idx = -1; m_rel = 1'b1; m_err = 1'b1;
            end
`endif
        end else if (m_rel) begin
            m_rel = 1'b0;
            m_err = 1'b0;
        end else if (V) begin
            m_idx  = int'({A, B});
            m_held = 0;
        end
    endtask

    function automatic logic [3:0] exp_g();
        logic [3:0] e;
        e = 4'b0000;
        if (m_idx >= 0) e[m_idx] = 1'b1;
        return e;
    endfunction

    function automatic logic exp_busy();
        return (m_idx >= 0) || m_rel;
    endfunction

    function automatic logic exp_err();
        return m_rel && m_err;
    endfunction

    // One clock of stimulus: drive at negedge, model updates at posedge, return at next negedge
    task automatic cycle(input logic v, input logic a, input logic b, input logic k);
        V = v; A = a; B = b; ack = k;
        @(posedge clk);
        model_step();
        @(negedge clk);
        $display("t=%0t V=%b AB=%b%b ack=%b -> G=%b busy=%b err=%b", $time, v, a, b, k, G, busy, err);
    endtask

    task automatic flush();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; V = 1'b0; A = 1'b0; B = 1'b0; ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (G !== 4'b0000) begin bad++; $display("FAIL reset_g: got %b want 0000", G); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            total++;
            if ({G, busy, err} !== 6'b000000) begin
                bad++; $display("FAIL idle_after_reset: got G=%b busy=%b err=%b want 0000/0/0", G, busy, err);
            end
        end
    endtask

    task automatic test_single_grant();
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        total++; if (G !== 4'b0100 || busy !== 1'b1) begin bad++; $display("FAIL single_first: got G=%b busy=%b want 0100/1", G, busy); end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0);
            total++; if (G !== 4'b0100) begin bad++; $display("FAIL single_hold: got %b want 0100", G); end
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (G !== 4'b0000 || busy !== 1'b1 || err !== 1'b0) begin
            bad++; $display("FAIL single_release: got G=%b busy=%b err=%b want 0000/1/0", G, busy, err);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (busy !== 1'b0 || G !== 4'b0000) begin bad++; $display("FAIL single_idle: got G=%b busy=%b want 0000/0", G, busy); end
    endtask

    task automatic test_request_while_busy();
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        total++; if (G !== 4'b1000) begin bad++; $display("FAIL busy_grant: got %b want 1000", G); end
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        total++; if (G !== 4'b1000) begin bad++; $display("FAIL busy_ignore_v: got %b want 1000", G); end
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        total++; if (G !== 4'b0000 || busy !== 1'b1) begin bad++; $display("FAIL busy_release: got G=%b busy=%b want 0000/1", G, busy); end
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        total++; if (G !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL release_drop_v: got G=%b busy=%b want 0000/0", G, busy); end
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        total++; if (G !== 4'b0010) begin bad++; $display("FAIL busy_next_grant: got %b want 0010", G); end
        flush();
    endtask

    task automatic test_mid_grant_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        total++; if (G !== 4'b0001) begin bad++; $display("FAIL mid_rst_grant: got %b want 0001", G); end
        #1 rst = 1'b1;
        #1;
        total++; if ({G, busy, err} !== 6'b000000) begin
            bad++; $display("FAIL mid_rst_async: got G=%b busy=%b err=%b want 0000/0/0", G, busy, err);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        total++; if (G !== 4'b1000 || busy !== 1'b1 || err !== 1'b0) begin
            bad++; $display("FAIL first_edge_capture: got G=%b busy=%b err=%b want 1000/1/0", G, busy, err);
        end
        flush();
    endtask

    task automatic test_timeout();
`ifdef GRANT_TIMEOUT_EN
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < TO - 1; i++) begin
            total++; if (G !== 4'b0100) begin bad++; $display("FAIL timeout_hold: got %b want 0100", G); end
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
        end
        total++; if (G !== 4'b0100) begin bad++; $display("FAIL timeout_last: got %b want 0100", G); end
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (G !== 4'b0000 || busy !== 1'b1 || err !== 1'b1) begin
            bad++; $display("FAIL timeout_err: got G=%b busy=%b err=%b want 0000/1/1", G, busy, err);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (err !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL timeout_err_pulse: got err=%b busy=%b want 0/0", err, busy); end
        // ack in the final permitted cycle wins over revocation
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < TO - 1; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (G !== 4'b0100) begin bad++; $display("FAIL tie_hold: got %b want 0100", G); end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (G !== 4'b0000 || busy !== 1'b1 || err !== 1'b0) begin
            bad++; $display("FAIL tie_no_err: got G=%b busy=%b err=%b want 0000/1/0", G, busy, err);
        end
`else
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            total++; if (G !== 4'b0100 || err !== 1'b0) begin
                bad++; $display("FAIL hold_forever: got G=%b err=%b want 0100/0", G, err);
            end
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (G !== 4'b0000 || busy !== 1'b1 || err !== 1'b0) begin
            bad++; $display("FAIL hold_release: got G=%b busy=%b err=%b want 0000/1/0", G, busy, err);
        end
`endif
        flush();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            total++; if ((G != 4'b0000) !== (i % 3 == 0)) begin
                bad++; $display("FAIL b2b_spacing: cycle %0d got G=%b want grant=%0d", i, G, (i % 3 == 0));
            end
            total++; if (G !== exp_g()) begin bad++; $display("FAIL b2b_value: got %b want %b", G, exp_g()); end
        end
        flush();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0));
            total++; if (G !== exp_g()) begin bad++; $display("FAIL rand_g: got %b want %b", G, exp_g()); end
            total++; if (busy !== exp_busy()) begin bad++; $display("FAIL rand_busy: got %b want %b", busy, exp_busy()); end
            total++; if (err !== exp_err()) begin bad++; $display("FAIL rand_err: got %b want %b", err, exp_err()); end
            total++; if ($countones(G) > 1) begin bad++; $display("FAIL rand_onehot: got %b want at most one bit", G); end
        end
        flush();
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_request_while_busy();
        test_mid_grant_reset();
        test_timeout();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/priority_grant_decoder.md
PRIORITY_GRANT_DECODER -- requirements
Module: priority_grant_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 8: cycles a grant may stay unacknowledged before revocation; legal range 2..255; used only when GRANT_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 A  input  1  encoded index MSB, from the 4-to-2 priority encoder.
REQ-005 B  input  1  encoded index LSB.
REQ-006 V  input  1  index valid; A/B are ignored when V=0.
REQ-007 ack  input  1  grantee acknowledge; single-cycle pulse or level.
REQ-008 G  output  4  one-hot grant; G[{A,B}] is asserted.
REQ-009 busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 err  output  1  one-cycle timeout pulse; tied 0 when GRANT_TIMEOUT_EN is undefined.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, GRANT and RELEASE.
REQ-012 IDLE: G=0, busy=0; on a rising edge with V=1, the block SHALL capture idx={A,B} and move to GRANT.
REQ-013 Latency SHALL be 1 cycle: V sampled at edge N makes G=onehot(idx) and busy=1 visible after edge N.
REQ-014 GRANT: G SHALL hold onehot(idx) and V/A/B SHALL be ignored; ack=1 at an edge moves the FSM to RELEASE.
REQ-015 RELEASE: G=0, busy=1 for exactly one cycle, then IDLE unconditionally; V during RELEASE SHALL be dropped.
REQ-016 Back-to-back requests SHALL give a minimum grant-to-grant spacing of 3 cycles: GRANT, then RELEASE, then IDLE capture.
REQ-017 G SHALL be registered, never glitch, and never have more than one bit set.
REQ-018 ack in IDLE or RELEASE SHALL be ignored.
REQ-019 idx SHALL be captured once per grant and SHALL NOT change until the FSM returns to IDLE.

Reset
REQ-020 rst=1 SHALL immediately, without a clock, force state=IDLE, G=4'b0000, busy=0, err=0, idx=0 and the timeout counter=0.
REQ-021 rst asserted mid-GRANT SHALL drop G asynchronously and SHALL NOT generate err.
REQ-022 On the first edge after rst deasserts, V=1 SHALL be captured normally.

Configuration
REQ-023 Macro GRANT_TIMEOUT_EN, when defined, SHALL add an 8-bit counter that clears on entry to GRANT and increments each GRANT cycle without ack.
REQ-024 With the macro defined, when the counter reaches TIMEOUT_CYCLES-1 with ack=0, the FSM SHALL go to RELEASE and err SHALL pulse high for the RELEASE cycle.
REQ-025 With the macro defined, ack=1 in the timeout cycle SHALL win: the FSM goes to RELEASE normally and err stays 0.
REQ-026 With the macro undefined, there SHALL be no counter, GRANT SHALL be held indefinitely until ack, and err SHALL be constant 0.

Structure
REQ-027 Shared package priority_grant_pkg SHALL hold the state encoding constants (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2) and the index width (2).
REQ-028 The one-hot decode SHALL be a combinational sub-module dec_2to4 (in: 2-bit idx; out: 4-bit one-hot) instantiated once, with its output registered into G.

Verification
REQ-029 Reset then idle: rst=1, then release with V=0 -> G=0000, busy=0, err=0 for 5 cycles.
REQ-030 Single grant: V=1, A=1, B=0 for one cycle; ack after 3 cycles -> G=0100 on cycle 1, held until ack; G=0000 with busy=1 for one cycle; then busy=0.
REQ-031 Request while busy: in GRANT idx=3, V=1 with A=0, B=1 -> G stays 1000; after ack and RELEASE, a new V with {A,B}=01 gives G=0010.
REQ-032 Mid-grant reset: grant G=0001 active, rst pulsed between edges -> G=0000 and busy=0 before the next edge; err=0.
REQ-033 Timeout (macro defined, TIMEOUT_CYCLES=4): grant idx=2 with no ack -> G=0100 for 4 cycles, then RELEASE with err=1 for exactly 1 cycle.
REQ-034 Timeout tie (macro defined, TIMEOUT_CYCLES=4): ack=1 in the 4th GRANT cycle -> RELEASE with err=0.
